// File: rtl/csi2_capture_controller.sv
// Frame capture sequencer for a decoded CSI-2 packet stream. It arms on start, locks onto Frame Start
// on one virtual channel, forwards long-packet beats, and tracks line/frame counts and errors.
module csi2_capture_controller #(
    parameter int unsigned LINE_BYTES  = 0,
    parameter int unsigned FRAME_LINES = 0
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [7:0]      num_frames_i,
    input  logic [1:0]      vc_select_i,
    input  logic [1:0]      virtual_channel_i,
    input  logic [15:0]     word_count_i,
    input  logic [5:0]      image_data_type_i,
    input  logic [3:0][7:0] image_data_i,
    input  logic            image_data_enable_i,
    input  logic            interrupt_i,
    output logic [3:0][7:0] out_data_o,
    output logic            out_enable_o,
    output logic            frame_valid_o,
    output logic            line_valid_o,
    output logic [15:0]     line_count_o,
    output logic [7:0]      frame_count_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_sequence_o,
    output logic            err_length_o
);

    localparam logic [15:0] LINE_BYTES_W  = 16'(LINE_BYTES);
    localparam logic [15:0] FRAME_LINES_W = 16'(FRAME_LINES);

    // S_WAIT sits between captured frames: like S_ARMED, but a long packet there is a sequence error.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_FRAME,
        S_LINE,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic            irq_q;
    logic [1:0]      vc_q, vc_d;
    logic [7:0]      num_q, num_d;
    logic [15:0]     wc_q, wc_d;
    logic [15:0]     beat_q, beat_d;
    logic [15:0]     line_q, line_d;
    logic [7:0]      frame_q, frame_d;
    logic [3:0][7:0] out_data_q, out_data_d;
    logic            out_en_q, out_en_d;
    logic            done_q, done_d;
    logic            err_seq_q, err_seq_d;
    logic            err_len_q, err_len_d;

    logic            hdr, fall, vc_hit;
    logic            is_fs, is_fe, is_long;
    logic [16:0]     beats_total, beats_expected;
    logic [7:0]      frame_inc;

    always_comb begin
        hdr            = interrupt_i & ~irq_q;
        fall           = ~interrupt_i & irq_q;
        vc_hit         = (virtual_channel_i == vc_q);
        is_fs          = hdr && vc_hit && (image_data_type_i == 6'h00);
        is_fe          = hdr && vc_hit && (image_data_type_i == 6'h01);
        is_long        = hdr && vc_hit && (image_data_type_i >= 6'h10);
        beats_total    = {1'b0, beat_q} + {16'd0, image_data_enable_i};
        beats_expected = ({1'b0, wc_q} + 17'd3) >> 2;
        frame_inc      = (frame_q == 8'hFF) ? 8'hFF : frame_q + 8'd1;

        state_d    = state_q;
        vc_d       = vc_q;
        num_d      = num_q;
        wc_d       = wc_q;
        beat_d     = beat_q;
        line_d     = line_q;
        frame_d    = frame_q;
        out_data_d = out_data_q;
        out_en_d   = 1'b0;
        done_d     = 1'b0;
        err_seq_d  = err_seq_q;
        err_len_d  = err_len_q;

        if (abort_i) begin
            // Errors survive an abort so software can still inspect why it stopped.
            state_d    = S_IDLE;
            beat_d     = '0;
            line_d     = '0;
            frame_d    = '0;
            out_data_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d   = S_ARMED;
                        vc_d      = vc_select_i;
                        num_d     = num_frames_i;
                        line_d    = '0;
                        frame_d   = '0;
                        err_seq_d = 1'b0;
                        err_len_d = 1'b0;
                    end
                end
                S_ARMED, S_WAIT: begin
                    if (is_fs) begin
                        state_d = S_FRAME;
                        line_d  = '0;
                    end else if (is_long && state_q == S_WAIT) begin
                        err_seq_d = 1'b1;
                    end
                end
                S_FRAME: begin
                    if (is_long) begin
                        state_d = S_LINE;
                        wc_d    = word_count_i;
                        beat_d  = '0;
                    end else if (is_fs) begin
                        err_seq_d = 1'b1;
                        line_d    = '0;
                    end else if (is_fe) begin
                        frame_d = frame_inc;
                        if (FRAME_LINES != 0 && line_q != FRAME_LINES_W) begin
                            err_len_d = 1'b1;
                        end
                        if (num_q != 8'd0 && frame_inc == num_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_LINE: begin
                    if (image_data_enable_i) begin
                        out_data_d = image_data_i;
                        out_en_d   = 1'b1;
                        beat_d     = beat_q + 16'd1;
                    end
                    if (fall) begin
                        state_d = S_FRAME;
                        line_d  = line_q + 16'd1;
                        if (beats_total != beats_expected ||
                            (LINE_BYTES != 0 && wc_q != LINE_BYTES_W)) begin
                            err_len_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            irq_q      <= 1'b0;
            vc_q       <= '0;
            num_q      <= '0;
            wc_q       <= '0;
            beat_q     <= '0;
            line_q     <= '0;
            frame_q    <= '0;
            out_data_q <= '0;
            out_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_seq_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_q      <= interrupt_i;
            vc_q       <= vc_d;
            num_q      <= num_d;
            wc_q       <= wc_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            done_q     <= done_d;
            err_seq_q  <= err_seq_d;
            err_len_q  <= err_len_d;
        end
    end

    assign out_data_o     = out_data_q;
    assign out_enable_o   = out_en_q;
    assign frame_valid_o  = (state_q == S_FRAME) || (state_q == S_LINE);
    assign line_valid_o   = (state_q == S_LINE);
    assign line_count_o   = line_q;
    assign frame_count_o  = frame_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign err_sequence_o = err_seq_q;
    assign err_length_o   = err_len_q;

endmodule

// File: tb/tb_csi2_capture_controller.sv
// Randomized self-checking bench for csi2_capture_controller against a packet-level reference model.
module tb_csi2_capture_controller;

    localparam int LB = 8;
    localparam int FL = 2;

    logic            clk = 1'b0;
    logic            reset_i, start_i, abort_i;
    logic [7:0]      num_frames_i;
    logic [1:0]      vc_select_i, virtual_channel_i;
    logic [15:0]     word_count_i;
    logic [5:0]      image_data_type_i;
    logic [3:0][7:0] image_data_i;
    logic            image_data_enable_i, interrupt_i;
    logic [3:0][7:0] out_data_o;
    logic            out_enable_o, frame_valid_o, line_valid_o;
    logic [15:0]     line_count_o;
    logic [7:0]      frame_count_o;
    logic            busy_o, done_o, err_sequence_o, err_length_o;

    always #5 clk = ~clk;

    csi2_capture_controller #(.LINE_BYTES(LB), .FRAME_LINES(FL)) dut (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
        .num_frames_i(num_frames_i), .vc_select_i(vc_select_i),
        .virtual_channel_i(virtual_channel_i), .word_count_i(word_count_i),
        .image_data_type_i(image_data_type_i), .image_data_i(image_data_i),
        .image_data_enable_i(image_data_enable_i), .interrupt_i(interrupt_i),
        .out_data_o(out_data_o), .out_enable_o(out_enable_o),
        .frame_valid_o(frame_valid_o), .line_valid_o(line_valid_o),
        .line_count_o(line_count_o), .frame_count_o(frame_count_o),
        .busy_o(busy_o), .done_o(done_o),
        .err_sequence_o(err_sequence_o), .err_length_o(err_length_o)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference model: capture session state at packet granularity.
    bit m_busy, m_fv, m_lv, m_between, m_errseq, m_errlen;
    int m_lines, m_frames, m_vc, m_num, m_wc;
    int exp_done = 0;
    int done_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] fixed_data[$];
    bit mon_en = 0;

    function automatic void model_start(int vc, int num);
        if (m_busy) return;
        m_busy = 1; m_fv = 0; m_lv = 0; m_between = 0;
        m_lines = 0; m_frames = 0; m_errseq = 0; m_errlen = 0;
        m_vc = vc; m_num = num;
    endfunction

    function automatic void model_abort();
        m_busy = 0; m_fv = 0; m_lv = 0; m_between = 0;
        m_lines = 0; m_frames = 0;
    endfunction

    function automatic void model_hdr(int vc, int dt, int wc);
        if (!m_busy || vc != m_vc) return;
        if (dt == 0) begin
            if (m_fv) m_errseq = 1;
            m_lines = 0; m_fv = 1; m_between = 0;
        end else if (dt == 1) begin
            if (m_fv) begin
                m_frames = (m_frames >= 255) ? 255 : m_frames + 1;
                if (FL != 0 && m_lines != FL) m_errlen = 1;
                m_fv = 0;
                if (m_num != 0 && m_frames == m_num) begin
                    m_busy = 0;
                    exp_done++;
                end else begin
                    m_between = 1;
                end
            end
        end else if (dt >= 16) begin
            if (m_fv) begin
                m_lv = 1; m_wc = wc;
            end else if (m_between) begin
                m_errseq = 1;
            end
        end
    endfunction

    function automatic void model_fall(int nbeats);
        if (!m_lv) return;
        m_lines = (m_lines + 1) % 65536;
        if (nbeats != (m_wc + 3) / 4 || (LB != 0 && m_wc != LB)) m_errlen = 1;
        m_lv = 0;
    endfunction

    // Cycle-level monitor: status flags and the forwarded beat stream.
    always @(negedge clk) begin
        if (mon_en) begin
            n_vec += 3;
            if (busy_o !== m_busy) begin
                n_mis++; $display("FAIL mon_busy: got %b want %b at %0t", busy_o, m_busy, $time);
            end
            if (frame_valid_o !== m_fv) begin
                n_mis++; $display("FAIL mon_frame_valid: got %b want %b at %0t", frame_valid_o, m_fv, $time);
            end
            if (line_valid_o !== m_lv) begin
                n_mis++; $display("FAIL mon_line_valid: got %b want %b at %0t", line_valid_o, m_lv, $time);
            end
            if (out_enable_o === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_mis++; $display("FAIL mon_unexpected_beat: got %h want none at %0t", out_data_o, $time);
                end else begin
                    logic [31:0] d;
                    d = exp_q.pop_front();
                    if (out_data_o !== d) begin
                        n_mis++; $display("FAIL mon_out_data: got %h want %h at %0t", out_data_o, d, $time);
                    end
                end
            end
            if (done_o === 1'b1) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(int vc, int num);
        start_i = 1; vc_select_i = 2'(vc); num_frames_i = 8'(num);
        tick();
        start_i = 0;
        model_start(vc, num);
    endtask

    task automatic do_abort();
        abort_i = 1;
        tick();
        abort_i = 0;
        model_abort();
    endtask

    task automatic send_pkt(int vc, int dt, int wc, int nbeats);
        bit cap;
        logic [31:0] d;
        interrupt_i = 1; virtual_channel_i = 2'(vc);
        image_data_type_i = 6'(dt); word_count_i = 16'(wc); image_data_enable_i = 0;
        tick();
        model_hdr(vc, dt, wc);
        cap = m_lv;
        if (dt >= 16) begin
            for (int b = 0; b < nbeats; b++) begin
                if ($urandom_range(3) == 0) tick();
                d = (fixed_data.size() != 0) ? fixed_data.pop_front() : $urandom;
                image_data_enable_i = 1; image_data_i = d;
                if (cap) exp_q.push_back(d);
                tick();
                image_data_enable_i = 0;
            end
        end else if ($urandom_range(1) == 1) begin
            tick();
        end
        interrupt_i = 0;
        tick();
        model_fall(nbeats);
        tick();
    endtask

    task automatic send_frame(int vc, int lines);
        send_pkt(vc, 0, 0, 0);
        for (int l = 0; l < lines; l++) send_pkt(vc, 8'h2A, LB, (LB + 3) / 4);
        send_pkt(vc, 1, 0, 0);
    endtask

    task automatic test_reset();
        reset_i = 1; start_i = 0; abort_i = 0; num_frames_i = 0; vc_select_i = 0;
        virtual_channel_i = 0; word_count_i = 0; image_data_type_i = 0; image_data_i = '0;
        image_data_enable_i = 0; interrupt_i = 0;
        repeat (3) tick();
        @(negedge clk);
        n_vec += 4;
        if ({out_enable_o, frame_valid_o, line_valid_o, busy_o, done_o} !== 5'b0) begin
            n_mis++; $display("FAIL reset_flags: got %b want 00000",
                {out_enable_o, frame_valid_o, line_valid_o, busy_o, done_o});
        end
        if (out_data_o !== 32'h0) begin
            n_mis++; $display("FAIL reset_out_data: got %h want 0", out_data_o);
        end
        if (line_count_o !== 16'd0 || frame_count_o !== 8'd0) begin
            n_mis++; $display("FAIL reset_counts: got %0d/%0d want 0/0", line_count_o, frame_count_o);
        end
        if (err_sequence_o !== 1'b0 || err_length_o !== 1'b0) begin
            n_mis++; $display("FAIL reset_errors: got %b%b want 00", err_sequence_o, err_length_o);
        end
        reset_i = 0;
        tick();
        mon_en = 1;
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        int d0 = done_seen;
        do_start(0, 1);
        send_frame(0, 2);
        n_vec += 5;
        if (line_count_o !== 16'd2) begin
            n_mis++; $display("FAIL t1_line_count: got %0d want 2", line_count_o);
        end
        if (frame_count_o !== 8'd1) begin
            n_mis++; $display("FAIL t1_frame_count: got %0d want 1", frame_count_o);
        end
        if (done_seen - d0 != 1) begin
            n_mis++; $display("FAIL t1_done_cycles: got %0d want 1", done_seen - d0);
        end
        if (busy_o !== 1'b0) begin
            n_mis++; $display("FAIL t1_busy: got %b want 0", busy_o);
        end
        if (err_sequence_o !== 1'b0 || err_length_o !== 1'b0) begin
            n_mis++; $display("FAIL t1_errors: got %b%b want 00", err_sequence_o, err_length_o);
        end
        $display("test_single_frame done");
    endtask

    task automatic test_data_order();
        do_start(0, 1);
        send_pkt(0, 0, 0, 0);
        fixed_data.push_back(32'h0D15EA5E);
        fixed_data.push_back(32'hFEE1DEAD);
        send_pkt(0, 8'h24, 8, 2);
        n_vec += 2;
        if (exp_q.size() != 0) begin
            n_mis++; $display("FAIL t2_beats_pending: got %0d want 0", exp_q.size());
        end
        if (out_data_o !== 32'hFEE1DEAD) begin
            n_mis++; $display("FAIL t2_last_data: got %h want fee1dead", out_data_o);
        end
        send_pkt(0, 8'h24, 8, 2);
        send_pkt(0, 1, 0, 0);
        $display("test_data_order done");
    endtask

    task automatic test_vc_filter();
        int d0 = done_seen;
        do_start(1, 1);
        send_frame(0, 2);
        n_vec += 3;
        if (busy_o !== 1'b1) begin
            n_mis++; $display("FAIL t3_busy: got %b want 1", busy_o);
        end
        if (frame_count_o !== 8'd0 || line_count_o !== 16'd0) begin
            n_mis++; $display("FAIL t3_counts: got %0d/%0d want 0/0", frame_count_o, line_count_o);
        end
        if (done_seen != d0) begin
            n_mis++; $display("FAIL t3_done: got %0d want %0d", done_seen, d0);
        end
        send_frame(1, 2);
        n_vec++;
        if (done_seen - d0 != 1 || busy_o !== 1'b0) begin
            n_mis++; $display("FAIL t3_vc1_done: got %0d/%b want 1/0", done_seen - d0, busy_o);
        end
        $display("test_vc_filter done");
    endtask

    task automatic test_length();
        do_start(0, 1);
        send_pkt(0, 0, 0, 0);
        send_pkt(0, 8'h2B, 8, 2);
        n_vec++;
        if (err_length_o !== 1'b0) begin
            n_mis++; $display("FAIL t4_len_ok: got %b want 0", err_length_o);
        end
        send_pkt(0, 8'h2B, 12, 3);
        n_vec += 2;
        if (err_length_o !== 1'b1) begin
            n_mis++; $display("FAIL t4_len_line_bytes: got %b want 1", err_length_o);
        end
        if (exp_q.size() != 0) begin
            n_mis++; $display("FAIL t4_forwarded: got %0d pending want 0", exp_q.size());
        end
        send_pkt(0, 1, 0, 0);
        do_start(0, 1);
        n_vec++;
        if (err_length_o !== 1'b0) begin
            n_mis++; $display("FAIL t4_cleared_by_start: got %b want 0", err_length_o);
        end
        send_pkt(0, 0, 0, 0);
        send_pkt(0, 8'h2B, 8, 1);
        n_vec++;
        if (err_length_o !== 1'b1) begin
            n_mis++; $display("FAIL t4_beat_count: got %b want 1", err_length_o);
        end
        send_pkt(0, 1, 0, 0);
        $display("test_length done");
    endtask

    task automatic test_sequence();
        int d0;
        do_start(0, 1);
        send_pkt(0, 0, 0, 0);
        send_pkt(0, 8'h2A, 8, 2);
        send_pkt(0, 0, 0, 0);
        n_vec += 2;
        if (err_sequence_o !== 1'b1) begin
            n_mis++; $display("FAIL t5_double_fs: got %b want 1", err_sequence_o);
        end
        if (line_count_o !== 16'd0) begin
            n_mis++; $display("FAIL t5_line_restart: got %0d want 0", line_count_o);
        end
        send_pkt(0, 8'h2A, 8, 2);
        send_pkt(0, 8'h2A, 8, 2);
        send_pkt(0, 1, 0, 0);
        d0 = done_seen;
        send_pkt(0, 1, 0, 0);
        n_vec++;
        if (frame_count_o !== 8'd1 || line_count_o !== 16'd2 || busy_o !== 1'b0 || done_seen != d0) begin
            n_mis++; $display("FAIL t5_fe_after_done: got %0d/%0d/%b/%0d want 1/2/0/%0d",
                frame_count_o, line_count_o, busy_o, done_seen, d0);
        end
        do_start(0, 2);
        n_vec++;
        if (err_sequence_o !== 1'b0) begin
            n_mis++; $display("FAIL t5_cleared_by_start: got %b want 0", err_sequence_o);
        end
        send_frame(0, 2);
        send_pkt(0, 8'h30, 8, 2);
        n_vec++;
        if (err_sequence_o !== 1'b1) begin
            n_mis++; $display("FAIL t5_long_between: got %b want 1", err_sequence_o);
        end
        send_pkt(0, 1, 0, 0);
        send_frame(0, 2);
        n_vec++;
        if (frame_count_o !== 8'd2 || busy_o !== 1'b0) begin
            n_mis++; $display("FAIL t5_second_frame: got %0d/%b want 2/0", frame_count_o, busy_o);
        end
        $display("test_sequence done");
    endtask

    task automatic test_continuous_abort();
        int d0 = done_seen;
        logic [31:0] d;
        do_start(0, 0);
        repeat (3) send_frame(0, 2);
        n_vec += 2;
        if (frame_count_o !== 8'd3 || busy_o !== 1'b1) begin
            n_mis++; $display("FAIL t6_three_frames: got %0d/%b want 3/1", frame_count_o, busy_o);
        end
        if (done_seen != d0) begin
            n_mis++; $display("FAIL t6_no_done: got %0d want %0d", done_seen, d0);
        end
        send_pkt(0, 0, 0, 0);
        interrupt_i = 1; virtual_channel_i = 0; image_data_type_i = 6'h2A; word_count_i = 16'd8;
        tick();
        model_hdr(0, 8'h2A, 8);
        for (int b = 0; b < 2; b++) begin
            d = $urandom;
            image_data_enable_i = 1; image_data_i = d;
            exp_q.push_back(d);
            tick();
        end
        image_data_enable_i = 0;
        do_abort();
        n_vec += 2;
        if ({out_enable_o, frame_valid_o, line_valid_o, busy_o, done_o} !== 5'b0 || out_data_o !== 32'h0) begin
            n_mis++; $display("FAIL t6_abort_outputs: got %b/%h want 00000/0",
                {out_enable_o, frame_valid_o, line_valid_o, busy_o, done_o}, out_data_o);
        end
        if (frame_count_o !== 8'd0 || line_count_o !== 16'd0) begin
            n_mis++; $display("FAIL t6_abort_counts: got %0d/%0d want 0/0", frame_count_o, line_count_o);
        end
        tick();
        interrupt_i = 0;
        repeat (2) tick();
        start_i = 1; abort_i = 1;
        tick();
        start_i = 0; abort_i = 0;
        n_vec += 2;
        if (busy_o !== 1'b0) begin
            n_mis++; $display("FAIL t6_abort_beats_start: got %b want 0", busy_o);
        end
        if (done_seen != d0) begin
            n_mis++; $display("FAIL t6_done_after_abort: got %0d want %0d", done_seen, d0);
        end
        $display("test_continuous_abort done");
    endtask

    task automatic test_saturate();
        do_start(2, 0);
        for (int f = 0; f < 257; f++) begin
            send_pkt(2, 0, 0, 0);
            send_pkt(2, 1, 0, 0);
        end
        n_vec++;
        if (frame_count_o !== 8'd255) begin
            n_mis++; $display("FAIL sat_frame_count: got %0d want 255", frame_count_o);
        end
        do_abort();
        $display("test_saturate done");
    endtask

    task automatic test_random();
        int kind, vc, dt, wc, nb;
        for (int r = 0; r < 6; r++) begin
            do_start($urandom_range(3), $urandom_range(3));
            for (int p = 0; p < 30; p++) begin
                if ($urandom_range(15) == 0) do_start($urandom_range(3), $urandom_range(3));
                kind = $urandom_range(5);
                vc = (kind == 5) ? $urandom_range(3) : m_vc;
                case (kind)
                    0:       dt = 0;
                    1:       dt = 1;
                    2:       dt = $urandom_range(2, 15);
                    default: dt = $urandom_range(16, 63);
                endcase
                wc = ($urandom_range(1) == 1) ? LB : $urandom_range(1, 20);
                nb = (wc + 3) / 4;
                if ($urandom_range(3) == 0) nb = nb + 1;
                send_pkt(vc, dt, wc, nb);
                n_vec += 5;
                if (line_count_o !== 16'(m_lines)) begin
                    n_mis++; $display("FAIL rnd_line_count: got %0d want %0d", line_count_o, m_lines);
                end
                if (frame_count_o !== 8'(m_frames)) begin
                    n_mis++; $display("FAIL rnd_frame_count: got %0d want %0d", frame_count_o, m_frames);
                end
                if (err_sequence_o !== m_errseq) begin
                    n_mis++; $display("FAIL rnd_err_sequence: got %b want %b", err_sequence_o, m_errseq);
                end
                if (err_length_o !== m_errlen) begin
                    n_mis++; $display("FAIL rnd_err_length: got %b want %b", err_length_o, m_errlen);
                end
                if (done_seen != exp_done) begin
                    n_mis++; $display("FAIL rnd_done: got %0d want %0d", done_seen, exp_done);
                end
            end
            do_abort();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_data_order();
        test_vc_filter();
        test_length();
        test_sequence();
        test_continuous_abort();
        test_saturate();
        test_random();
        repeat (2) tick();
        n_vec += 2;
        if (exp_q.size() != 0) begin
            n_mis++; $display("FAIL end_beats_missing: got %0d pending want 0", exp_q.size());
        end
        if (done_seen != exp_done) begin
            n_mis++; $display("FAIL end_done_total: got %0d want %0d", done_seen, exp_done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
